// File: rtl/contador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | contador_pkg                                                       |
// | Types and constants shared by the synchronous counter family.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package contador_pkg;

  localparam int CONTADOR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/contador_evento_sat.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | contador_evento_sat                                                |
// | 8-bit event counter that sticks at 255; clear yields to reset only.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module contador_evento_sat (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/contador_sincrono_decrescente.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | contador_sincrono_decrescente                                      |
// | Loadable down counter with terminal-count pulse and auto-reload.   |
// | Optional tc_count output under macro CONTADOR_DEC_TCCOUNT_EN.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module contador_sincrono_decrescente
  import contador_pkg::*;
#(
  parameter int               WIDTH       = CONTADOR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
`ifdef CONTADOR_DEC_TCCOUNT_EN
  ,
  output logic [7:0]       tc_count
`endif
);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;

  // State register together with the datapath registers it governs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= RESET_VALUE;
      reload_q <= RESET_VALUE;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state and datapath: load overrides everything; only RUN counts.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q == WIDTH'(1)) begin
              count_d = '0;
              tc_d    = 1'b1;
              state_d = auto_reload ? RUN : DONE;
            end else if (count_q == '0) begin
              // Only reachable after an auto-reload wrap: no pulse here.
              count_d = reload_q;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  assign Q        = count_q;
  assign zero     = (count_q == '0);
  assign tc_pulse = tc_q;

`ifdef CONTADOR_DEC_TCCOUNT_EN
  contador_evento_sat u_tc_count (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .inc   (tc_q),
    .count (tc_count)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_contador_sincrono_decrescente.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_contador_sincrono_decrescente                                   |
// | Directed and random stimulus against a behavioural counter model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_contador_sincrono_decrescente;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  wire  [W-1:0] Q;
  wire          zero;
  wire          tc_pulse;
  wire          busy;
`ifdef CONTADOR_DEC_TCCOUNT_EN
  wire  [7:0]   tc_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a count, the last loaded value, and whether it is counting.
  int m_q, m_rel, m_tcc;
  bit m_run, m_tc;

  contador_sincrono_decrescente #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .Q           (Q),
    .zero        (zero),
    .tc_pulse    (tc_pulse),
    .busy        (busy)
`ifdef CONTADOR_DEC_TCCOUNT_EN
    ,
    .tc_count    (tc_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit ld, input int lv, input bit en, input bit ar);
    if (rst) begin
      m_q = 0; m_rel = 0; m_run = 0; m_tc = 0; m_tcc = 0;
    end else if (ld) begin
      m_q = lv; m_rel = lv; m_tc = 0; m_run = (lv != 0); m_tcc = 0;
    end else begin
      if (m_tc && m_tcc < 255) m_tcc++;
      m_tc = 0;
      if (m_run && en) begin
        if (m_q == 1) begin
          m_q = 0; m_tc = 1; m_run = ar;
        end else if (m_q == 0) begin
          m_q = m_rel;
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("Q", {27'd0, Q}, m_q);
    chk("zero", {31'd0, zero}, (m_q == 0) ? 1 : 0);
    chk("tc_pulse", {31'd0, tc_pulse}, {31'd0, m_tc});
    chk("busy", {31'd0, busy}, {31'd0, m_run});
`ifdef CONTADOR_DEC_TCCOUNT_EN
    chk("tc_count", {24'd0, tc_count}, m_tcc);
`endif
  endtask

  // One clock: drive, clock, advance model, sample 1 ns after the edge.
  task automatic cycle(input bit rst, input bit ld, input int lv, input bit en, input bit ar);
    reset = rst; load = ld; load_value = W'(lv); enable = en; auto_reload = ar;
    @(posedge clk);
    model_step(rst, ld, lv, en, ar);
    #1;
    compare_all();
  endtask

  initial begin
    int lv;
    // Reset for two cycles then release
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_Q", {27'd0, Q}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    cycle(0, 0, 0, 1, 0);
    chk("idle_ignores_enable", {27'd0, Q}, 0);

    // Load 5, one-shot countdown to DONE
    cycle(0, 1, 5, 1, 0);
    chk("load5_Q", {27'd0, Q}, 5);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);
    chk("done_Q", {27'd0, Q}, 0);
    chk("done_busy", {31'd0, busy}, 0);

    // Load 3 with auto-reload, 12 enabled cycles
    cycle(0, 1, 3, 1, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);

    // Load 31, alternate enable, reset when Q reaches 20
    cycle(0, 1, 31, 0, 0);
    for (int i = 0; i < 40 && Q != W'(20); i++) cycle(0, 0, 0, (i % 2) == 0, 0);
    chk("reached_20", {27'd0, Q}, 20);
    cycle(1, 0, 0, 1, 0);
    chk("mid_reset_Q", {27'd0, Q}, 0);

    // Load vs enable priority at Q = 7
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 7, 0, 0);
    cycle(0, 1, 9, 1, 0);
    chk("load_over_enable", {27'd0, Q}, 9);
    cycle(0, 1, 0, 1, 0);
    chk("load0_tc", {31'd0, tc_pulse}, 0);
    cycle(0, 0, 0, 1, 1);

`ifdef CONTADOR_DEC_TCCOUNT_EN
    cycle(0, 1, 1, 1, 1);
    for (int i = 0; i < 600; i++) cycle(0, 0, 0, 1, 1);
    chk("tc_count_sat", {24'd0, tc_count}, 255);
    cycle(0, 1, 4, 0, 0);
    chk("tc_count_clear", {24'd0, tc_count}, 0);
`endif

    // Random stimulus
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, 31);
      else lv = $urandom_range(0, 4);
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, lv,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
